// File: rtl/ch2_piso_pkg.sv
// Shared definitions for the PISO transmit controller slice.
// Holds the FSM state encodings, the default word width and small helpers
// used by the controller, the interface and the shift register.
package ch2_piso_pkg;

    // Default parallel word width when a parent does not override it
    localparam int PISO_WIDTH = 4;

    // Controller state encodings; 2'd3 is never entered and decodes to idle
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Map any raw state value onto a legal state so a stray 2'd3 behaves as idle
    function automatic logic [1:0] decode_state(input logic [1:0] raw);
        if (raw == ST_SHIFT || raw == ST_GAP) begin
            return raw;
        end
        return ST_IDLE;
    endfunction

    // Gap counter width: enough to hold GAP-1, never narrower than one bit
    function automatic int gap_cnt_bits(input int gap);
        if (gap > 0) begin
            return $clog2(gap + 1);
        end
        return 1;
    endfunction

endpackage

// File: rtl/ch2_piso_tx_ctrl_if.sv
// Producer-facing handshake plus the serial framing outputs of the
// PISO transmit controller, bundled so both ends share one declaration.
interface ch2_piso_tx_ctrl_if
    import ch2_piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH
);

    // Parallel word and its valid/ready handshake
    logic [WIDTH-1:0] DIN;
    logic             DIN_VLD;
    logic             DIN_RDY;

    // Shift register control and serial framing
    logic             SH_LDN;
    logic             SOUT;
    logic             FRAME;
    logic             DONE;
    logic             BUSY;

    // Word producer / serial consumer side
    modport master (
        output DIN,
        output DIN_VLD,
        input  DIN_RDY,
        input  SH_LDN,
        input  SOUT,
        input  FRAME,
        input  DONE,
        input  BUSY
    );

    // Controller side
    modport slave (
        input  DIN,
        input  DIN_VLD,
        output DIN_RDY,
        output SH_LDN,
        output SOUT,
        output FRAME,
        output DONE,
        output BUSY
    );

endinterface

// File: rtl/ch2_piso_shreg.sv
// WIDTH-bit parallel-in / serial-out shift register.
// SH_LDN low loads D; otherwise the contents shift left with a zero entering
// at the LSB, so an unloaded register drains to all zeros. Q is the MSB.
module ch2_piso_shreg
    import ch2_piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SH_LDN,
    input  logic [WIDTH-1:0] D,
    output logic             Q
);

    logic [WIDTH-1:0] sreg;

    // Load on the accept edge, otherwise shift left one place every cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            sreg <= '0;
        end else if (!SH_LDN) begin
            sreg <= D;
        end else begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
        end
    end

    assign Q = sreg[WIDTH-1];

endmodule

// File: rtl/ch2_piso_tx_ctrl.sv
// Transmit controller around a PISO shift register.
// Accepts one word per valid/ready handshake while idle, streams it MSB first
// with FRAME high, pulses DONE on the last bit, then idles for GAP cycles
// before accepting the next word. Words offered while busy are ignored.
module ch2_piso_tx_ctrl
    import ch2_piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH,
    parameter int GAP   = 1
) (
    input  logic                CLK,
    input  logic                RST,
    ch2_piso_tx_ctrl_if.slave   bus
);

    localparam int         BW       = $clog2(WIDTH);
    localparam int         GW       = gap_cnt_bits(GAP);
    localparam logic       HAS_GAP  = (GAP > 0);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

    logic [1:0]    state;
    logic [1:0]    cur_state;
    logic [BW-1:0] bit_cnt;
    logic [GW-1:0] gap_cnt;
    logic          in_idle;
    logic          in_shift;
    logic          in_gap;
    logic          accept;
    logic          last_bit;
    logic          sh_ldn;
    logic          sout;

    assign cur_state = decode_state(state);
    assign in_idle   = (cur_state == ST_IDLE);
    assign in_shift  = (cur_state == ST_SHIFT);
    assign in_gap    = (cur_state == ST_GAP);

    // Reset suppresses acceptance so a producer holding VALID through reset
    // is not loaded on the reset edge
    assign accept    = bus.DIN_VLD & in_idle & ~RST;
    assign last_bit  = in_shift && (bit_cnt == '0);
    assign sh_ldn    = ~accept;

    // Sequence idle -> shift WIDTH bits -> optional gap -> idle
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            case (cur_state)
                ST_SHIFT: begin
                    if (bit_cnt == '0) begin
                        if (HAS_GAP) begin
                            state   <= ST_GAP;
                            gap_cnt <= GAP_LAST;
                        end else begin
                            state   <= ST_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    if (accept) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= BIT_LAST;
                    end
                end
            endcase
        end
    end

    ch2_piso_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .CLK    (CLK),
        .RST    (RST),
        .SH_LDN (sh_ldn),
        .D      (bus.DIN),
        .Q      (sout)
    );

    assign bus.DIN_RDY = in_idle;
    assign bus.SH_LDN  = sh_ldn;
    assign bus.SOUT    = sout;
    assign bus.FRAME   = in_shift;
    assign bus.DONE    = last_bit;
    assign bus.BUSY    = in_shift | in_gap;

endmodule

// File: doc/ch2_piso_tx_ctrl.md
# ch2_piso_tx_ctrl

Transmit controller wrapping a WIDTH-bit parallel-in/serial-out shift register. Accepts parallel words over a valid/ready handshake, generates the active-low load / active-high shift control (SH_LDN) for the register, and frames the MSB-first serial stream with FRAME and DONE. Sits between a word producer and any serial consumer that needs bit-level framing.

## Interface
- WIDTH, 4, word width in bits; legal range 2..16
- GAP, 1, idle cycles inserted after each word; 0 legal
- CLK  input  1  clock; all logic on rising edge
- RST  input  1  synchronous, active-high reset
- DIN  input  WIDTH  parallel word; sampled on accept
- DIN_VLD  input  1  producer has a word
- DIN_RDY  output  1  controller can accept; high only in IDLE
- SH_LDN  output  1  register control: 0 = load DIN this edge, 1 = shift left, 0 in at LSB
- SOUT  output  1  serial data = register MSB
- FRAME  output  1  high while SOUT carries a valid data bit
- DONE  output  1  one-cycle pulse on the last data bit of a word
- BUSY  output  1  high in SHIFT or GAP

## Operation
- Reset values: state IDLE, register 0, counters 0, DIN_RDY=1, SH_LDN=1, SOUT=0, FRAME=0, DONE=0, BUSY=0.
- Accept = DIN_VLD & DIN_RDY, sampled at a rising edge.
- SH_LDN = ~accept, combinational. Register loads DIN only on the accept edge; otherwise it shifts every cycle, so IDLE and GAP drain zeros and SOUT=0 outside frames.
- States:
  - IDLE: DIN_RDY=1. Accept -> SHIFT, bit counter = WIDTH-1.
  - SHIFT: FRAME=1, BUSY=1. Counter decrements each cycle. At counter 0: DONE=1. Next state is GAP if GAP>0 (gap counter = GAP-1), otherwise IDLE.
  - GAP: BUSY=1, FRAME=0, DIN_RDY=0. At gap counter 0 -> IDLE.
- DIN_VLD and DIN are ignored outside IDLE. No buffering: the producer holds DIN_VLD/DIN until the accept edge.
- RST has priority over everything. RST mid-frame returns all state to reset values at the next edge; the word in flight is dropped and no DONE is issued.
- Counter widths: $clog2(WIDTH) for the bit counter; $clog2(GAP+1), minimum 1, for the gap counter.

## Timing
- Accept at edge k. In cycles k+1..k+WIDTH, SOUT = DIN[WIDTH-1], DIN[WIDTH-2], ..., DIN[0], and FRAME=1.
- DONE=1 in cycle k+WIDTH only.
- GAP cycles follow: k+WIDTH+1..k+WIDTH+GAP. DIN_RDY returns high in cycle k+WIDTH+GAP+1.
- Maximum throughput is one word per WIDTH+GAP+1 cycles. The accept cycle in IDLE always shows SOUT=0 and FRAME=0.
- Latency from accept to the first data bit is 1 cycle.

## Structure
- Shared package ch2_piso_pkg:
  - state encodings IDLE=2'd0, SHIFT=2'd1, GAP=2'd2; 2'd3 is unreachable and decodes to IDLE
  - default constant PISO_WIDTH=4
- Sub-module ch2_piso_shreg: WIDTH-bit register with ports CLK, RST, SH_LDN, D, Q, plus the semantics above (load on SH_LDN=0, otherwise shift left with 0 in, Q = MSB, sync clear on RST).
- Controller FSM and counters live in ch2_piso_tx_ctrl.

## Test plan
- Reset: hold RST high 2 cycles with DIN_VLD=1 -> no accept; DIN_RDY=1, SH_LDN=1, SOUT=0, FRAME=0, DONE=0, BUSY=0.
- Single word (WIDTH=4, GAP=1), DIN=4'b1101 accepted at edge k:
  - SOUT is 1,1,0,1 in cycles k+1..k+4 with FRAME high
  - DONE only in k+4
  - BUSY k+1..k+5
  - DIN_RDY high again in k+6
- Back-to-back: DIN_VLD held high, 4'b1101 then 4'b0010 -> SOUT stream 1,1,0,1,0 (gap),0 (accept),0,0,1,0. Exactly two DONE pulses, 6 cycles apart.
- Ignore while busy: pulse DIN_VLD with DIN=4'b1111 during bit 2 of a 4'b1001 frame -> SOUT stays 1,0,0,1; no extra accept.
- Reset mid-frame: assert RST after 2 bits of 4'b1011 -> next cycle FRAME=0, SOUT=0, DIN_RDY=1, no DONE. A subsequent 4'b0110 transmits cleanly.
- GAP=0, WIDTH=8: accept 8'hA5 -> SOUT 1,0,1,0,0,1,0,1, then DIN_RDY high in the cycle right after DONE.
